// File: rtl/fpu_out_pkg.sv
// Shared definitions for the FPU result output arbiter: ID/data field offsets and default sizes.
package fpu_out_pkg;

  localparam int DEF_NPIPE = 3;
  localparam int DEF_NCORE = 8;
  localparam int DEF_PAY_W = 142;

  // Per-pipe ID word: {core one-hot, thread}
  localparam int ID_THR_LSB  = 0;
  localparam int ID_THR_W    = 2;
  localparam int ID_CORE_LSB = 2;

  // CPX data bus: {valid, thread, payload}; offsets depend on the payload width
  function automatic int data_thr_lsb(input int pay_w);
    return pay_w;
  endfunction

  function automatic int data_vld_bit(input int pay_w);
    return pay_w + ID_THR_W;
  endfunction

endpackage

// File: rtl/fpu_out_fifo.sv
// Per-pipe result FIFO: DEPTH x W, pointer-based with a wrap bit for full/empty.
module fpu_out_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] head,
  output logic         empty,
  output logic         full
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [AW:0]  wr_ptr_q, wr_ptr_d;
  logic [AW:0]  rd_ptr_q, rd_ptr_d;
  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] mem_d [DEPTH];
  logic         do_push, do_pop;

  always_comb begin
    empty    = (wr_ptr_q == rd_ptr_q);
    full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    head     = mem_q[rd_ptr_q[AW-1:0]];
    do_push  = push & ~full;
    do_pop   = pop & ~empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    mem_d    = mem_q;
    if (do_push) begin
      mem_d[wr_ptr_q[AW-1:0]] = wdata;
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage carries no reset; occupancy is tracked solely by the pointers.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/fpu_out_arb.sv
// FPU result-to-CPX output arbiter: per-pipe FIFOs, one-entry request stage, registered data pulse.
// Optional macro FPU_OUT_RR_EN selects round-robin arbitration instead of fixed priority.
module fpu_out_arb
  import fpu_out_pkg::*;
#(
  parameter int NPIPE = DEF_NPIPE,
  parameter int NCORE = DEF_NCORE,
  parameter int PAY_W = DEF_PAY_W,
  parameter int DEPTH = 2
) (
  input  logic                      rclk,
  input  logic                      arst_l,
  input  logic [NPIPE-1:0]          pipe_vld,
  input  logic [NPIPE*(NCORE+2)-1:0] pipe_id,
  input  logic [NPIPE*PAY_W-1:0]    pipe_pay,
  output logic [NPIPE-1:0]          pipe_rdy,
  input  logic                      cpx_gnt,
  output logic [NCORE-1:0]          fp_cpx_req_cq,
  output logic [NPIPE-1:0]          req_pipe,
  output logic [PAY_W+2:0]          fp_cpx_data_ca,
  output logic                      drop_err
);

  localparam int ID_W    = NCORE + 2;
  localparam int ENT_W   = ID_W + PAY_W;
  localparam int D_THR   = data_thr_lsb(PAY_W);
  localparam int D_VLD   = data_vld_bit(PAY_W);

  logic [NPIPE-1:0] fifo_push, fifo_pop, fifo_empty, fifo_full, core_zero;
  logic [ENT_W-1:0] fifo_head [NPIPE];

  for (genvar i = 0; i < NPIPE; i++) begin : g_pipe
    assign core_zero[i] = ~|pipe_id[i*ID_W+ID_CORE_LSB +: NCORE];
    assign fifo_push[i] = pipe_vld[i] & ~fifo_full[i] & ~core_zero[i];

    fpu_out_fifo #(
      .DEPTH (DEPTH),
      .W     (ENT_W)
    ) u_fifo (
      .clk   (rclk),
      .rst_n (arst_l),
      .push  (fifo_push[i]),
      .pop   (fifo_pop[i]),
      .wdata ({pipe_id[i*ID_W +: ID_W], pipe_pay[i*PAY_W +: PAY_W]}),
      .head  (fifo_head[i]),
      .empty (fifo_empty[i]),
      .full  (fifo_full[i])
    );
  end

  assign pipe_rdy = ~fifo_full;

  logic                drop_err_q, drop_err_d;
  logic                rq_vld_q, rq_vld_d;
  logic [NCORE-1:0]    rq_core_q, rq_core_d;
  logic [ID_THR_W-1:0] rq_thread_q, rq_thread_d;
  logic [PAY_W-1:0]    rq_pay_q, rq_pay_d;
  logic [NPIPE-1:0]    rq_pipe_q, rq_pipe_d;
  logic [PAY_W+2:0]    data_q, data_d;
  logic [NPIPE-1:0]    win_oh;
  logic [ENT_W-1:0]    win_ent;
  logic                found, load;

`ifdef FPU_OUT_RR_EN
  localparam int PTR_W = (NPIPE > 1) ? $clog2(NPIPE) : 1;
  logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
  int               win_idx;
`endif

  always_comb begin
    win_oh  = '0;
    found   = 1'b0;
`ifdef FPU_OUT_RR_EN
    win_idx = 0;
    for (int k = 0; k < NPIPE; k++) begin
      int idx;
      idx = (int'(rr_ptr_q) + k) % NPIPE;
      if (!found && !fifo_empty[idx]) begin
        win_oh[idx] = 1'b1;
        win_idx     = idx;
        found       = 1'b1;
      end
    end
`else
    for (int k = 0; k < NPIPE; k++) begin
      if (!found && !fifo_empty[k]) begin
        win_oh[k] = 1'b1;
        found     = 1'b1;
      end
    end
`endif
    win_ent = '0;
    for (int k = 0; k < NPIPE; k++) begin
      if (win_oh[k]) win_ent = fifo_head[k];
    end

    // A grant frees the stage in the same cycle, so traffic streams without bubbles.
    load     = (~rq_vld_q | cpx_gnt) & found;
    fifo_pop = load ? win_oh : '0;

    rq_vld_d    = load ? 1'b1 : (cpx_gnt ? 1'b0 : rq_vld_q);
    rq_core_d   = load ? win_ent[PAY_W+ID_CORE_LSB +: NCORE]   : rq_core_q;
    rq_thread_d = load ? win_ent[PAY_W+ID_THR_LSB +: ID_THR_W] : rq_thread_q;
    rq_pay_d    = load ? win_ent[PAY_W-1:0]                    : rq_pay_q;
    rq_pipe_d   = load ? win_oh                                : rq_pipe_q;

`ifdef FPU_OUT_RR_EN
    rr_ptr_d = rr_ptr_q;
    if (load) rr_ptr_d = (win_idx == NPIPE - 1) ? '0 : PTR_W'(win_idx + 1);
`endif

    data_d = '0;
    if (rq_vld_q && cpx_gnt) begin
      data_d[D_VLD]              = 1'b1;
      data_d[D_THR +: ID_THR_W]  = rq_thread_q;
      data_d[PAY_W-1:0]          = rq_pay_q;
    end

    drop_err_d = drop_err_q | (|(pipe_vld & ~fifo_full & core_zero));
  end

  always_ff @(posedge rclk or negedge arst_l) begin
    if (!arst_l) begin
      rq_vld_q   <= 1'b0;
      data_q     <= '0;
      drop_err_q <= 1'b0;
    end else begin
      rq_vld_q   <= rq_vld_d;
      data_q     <= data_d;
      drop_err_q <= drop_err_d;
    end
  end

`ifdef FPU_OUT_RR_EN
  always_ff @(posedge rclk or negedge arst_l) begin
    if (!arst_l) rr_ptr_q <= '0;
    else         rr_ptr_q <= rr_ptr_d;
  end
`endif

  // Request payload is qualified by rq_vld_q everywhere it is observed.
  always_ff @(posedge rclk) begin
    rq_core_q   <= rq_core_d;
    rq_thread_q <= rq_thread_d;
    rq_pay_q    <= rq_pay_d;
    rq_pipe_q   <= rq_pipe_d;
  end

  assign fp_cpx_req_cq  = rq_vld_q ? rq_core_q : '0;
  assign req_pipe       = rq_vld_q ? rq_pipe_q : '0;
  assign fp_cpx_data_ca = data_q;
  assign drop_err       = drop_err_q;

endmodule

// File: tb/tb_fpu_out_arb.sv
// Directed bench for fpu_out_arb at default sizes (NPIPE=3, NCORE=8, PAY_W=142, DEPTH=2).
module tb_fpu_out_arb;

  localparam int NP = 3;
  localparam int NC = 8;
  localparam int PW = 142;
  localparam int IW = NC + 2;

  logic                rclk = 1'b0;
  logic                arst_l;
  logic [NP-1:0]       pipe_vld;
  logic [NP*IW-1:0]    pipe_id;
  logic [NP*PW-1:0]    pipe_pay;
  logic [NP-1:0]       pipe_rdy;
  logic                cpx_gnt;
  logic [NC-1:0]       fp_cpx_req_cq;
  logic [NP-1:0]       req_pipe;
  logic [PW+2:0]       fp_cpx_data_ca;
  logic                drop_err;

  int total = 0;
  int bad   = 0;

  fpu_out_arb #(.NPIPE(NP), .NCORE(NC), .PAY_W(PW), .DEPTH(2)) dut (
    .rclk           (rclk),
    .arst_l         (arst_l),
    .pipe_vld       (pipe_vld),
    .pipe_id        (pipe_id),
    .pipe_pay       (pipe_pay),
    .pipe_rdy       (pipe_rdy),
    .cpx_gnt        (cpx_gnt),
    .fp_cpx_req_cq  (fp_cpx_req_cq),
    .req_pipe       (req_pipe),
    .fp_cpx_data_ca (fp_cpx_data_ca),
    .drop_err       (drop_err)
  );

  always #5 rclk = ~rclk;

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge rclk);
    #1;
  endtask

  task automatic set_pipe(input int p, input logic v, input logic [NC-1:0] core,
                          input logic [1:0] thr, input logic [PW-1:0] pay);
    pipe_vld[p]            = v;
    pipe_id[p*IW +: IW]    = {core, thr};
    pipe_pay[p*PW +: PW]   = pay;
  endtask

  function automatic logic [PW+2:0] dat(input logic [1:0] thr, input logic [PW-1:0] pay);
    return {1'b1, thr, pay};
  endfunction

  logic [PW-1:0] pa, pb, pc, pd, p1, px, py, pz;
  logic [NP-1:0] exp_pipe [4];
  logic [NC-1:0] exp_core [4];

  initial begin
    pa = 142'h0A0A; pb = 142'h0B0B; pc = 142'h0C0C; pd = 142'h0D0D;
    p1 = 142'h1234_5678; px = 142'h7777_0001; py = 142'h7777_0002; pz = 142'h3_DEAD_BEEF;
`ifdef FPU_OUT_RR_EN
    exp_pipe = '{3'b001, 3'b010, 3'b100, 3'b001};
    exp_core = '{8'h01, 8'h02, 8'h04, 8'h01};
`else
    exp_pipe = '{3'b001, 3'b001, 3'b001, 3'b001};
    exp_core = '{8'h01, 8'h01, 8'h01, 8'h01};
`endif
    arst_l = 1'b0; pipe_vld = '0; pipe_id = '0; pipe_pay = '0; cpx_gnt = 1'b0;

    // Reset values
    cyc(); cyc();
    chk("rst_req", fp_cpx_req_cq, 8'h00);
    chk("rst_req_pipe", req_pipe, 3'b000);
    chk("rst_data", fp_cpx_data_ca, '0);
    chk("rst_drop", drop_err, 1'b0);
    chk("rst_rdy", pipe_rdy, 3'b111);
    arst_l = 1'b1;
    cyc();

    // Single result from pipe 1, grant held high
    cpx_gnt = 1'b1;
    set_pipe(1, 1'b1, 8'h04, 2'b10, p1);
    cyc();
    set_pipe(1, 1'b0, 8'h00, 2'b00, '0);
    chk("t1_no_bypass", fp_cpx_req_cq, 8'h00);
    cyc();
    chk("t1_req", fp_cpx_req_cq, 8'h04);
    chk("t1_req_pipe", req_pipe, 3'b010);
    chk("t1_gnt_no_req_ignored", fp_cpx_data_ca, '0);
    cyc();
    chk("t1_data", fp_cpx_data_ca, dat(2'b10, p1));
    chk("t1_req_clear", fp_cpx_req_cq, 8'h00);
    cyc();
    chk("t1_data_pulse_end", fp_cpx_data_ca, '0);

    // Backpressure: pipe 0 pushes every cycle, no grant
    cpx_gnt = 1'b0;
    set_pipe(0, 1'b1, 8'h01, 2'b00, pa);
    cyc();
    chk("t2_rdy_e1", pipe_rdy[0], 1'b1);
    chk("t2_req_e1", fp_cpx_req_cq, 8'h00);
    set_pipe(0, 1'b1, 8'h01, 2'b00, pb);
    cyc();
    chk("t2_req_e2", fp_cpx_req_cq, 8'h01);
    chk("t2_rdy_e2", pipe_rdy[0], 1'b1);
    chk("t2_data_e2", fp_cpx_data_ca, '0);
    set_pipe(0, 1'b1, 8'h01, 2'b00, pc);
    cyc();
    chk("t2_req_e3", fp_cpx_req_cq, 8'h01);
    chk("t2_rdy_full", pipe_rdy[0], 1'b0);
    chk("t2_data_e3", fp_cpx_data_ca, '0);
    set_pipe(0, 1'b1, 8'h01, 2'b00, pd);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("t2_req_held", fp_cpx_req_cq, 8'h01);
      chk("t2_req_pipe_held", req_pipe, 3'b001);
      chk("t2_no_data", fp_cpx_data_ca, '0);
      chk("t2_rdy_held", pipe_rdy[0], 1'b0);
    end
    cpx_gnt = 1'b1;
    cyc();
    chk("t2_data_a", fp_cpx_data_ca, dat(2'b00, pa));
    chk("t2_req_b", fp_cpx_req_cq, 8'h01);
    chk("t2_rdy_rise", pipe_rdy[0], 1'b1);
    set_pipe(0, 1'b0, 8'h00, 2'b00, '0);
    cyc();
    chk("t2_data_b", fp_cpx_data_ca, dat(2'b00, pb));
    cyc();
    chk("t2_data_c", fp_cpx_data_ca, dat(2'b00, pc));
    chk("t2_drained", fp_cpx_req_cq, 8'h00);
    cyc();
    chk("t2_d_refused", fp_cpx_data_ca, '0);

    // Contention: all pipes push continuously, grant held
    set_pipe(0, 1'b1, 8'h01, 2'b00, pa);
    set_pipe(1, 1'b1, 8'h02, 2'b01, pb);
    set_pipe(2, 1'b1, 8'h04, 2'b11, pc);
    cyc();
    chk("t3_req_e1", fp_cpx_req_cq, 8'h00);
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("t3_req_pipe", req_pipe, exp_pipe[i]);
      chk("t3_req_core", fp_cpx_req_cq, exp_core[i]);
    end
    pipe_vld = '0;
    repeat (12) cyc();
    chk("t3_drain_req", fp_cpx_req_cq, 8'h00);
    chk("t3_drain_data", fp_cpx_data_ca, '0);
    chk("t3_drain_rdy", pipe_rdy, 3'b111);

    // Zero core field on pipe 2
    set_pipe(2, 1'b1, 8'h00, 2'b01, pd);
    cyc();
    set_pipe(2, 1'b0, 8'h00, 2'b00, '0);
    chk("t4_drop_set", drop_err, 1'b1);
    chk("t4_no_req_e1", fp_cpx_req_cq, 8'h00);
    cyc();
    chk("t4_no_req_e2", fp_cpx_req_cq, 8'h00);
    chk("t4_no_data", fp_cpx_data_ca, '0);
    repeat (3) cyc();
    chk("t4_drop_sticky", drop_err, 1'b1);

    // Async reset with a request pending and a data pulse on the bus
    cpx_gnt = 1'b0;
    set_pipe(1, 1'b1, 8'h08, 2'b01, px);
    cyc();
    set_pipe(1, 1'b1, 8'h08, 2'b01, py);
    cyc();
    set_pipe(1, 1'b0, 8'h00, 2'b00, '0);
    chk("t5_req_x", fp_cpx_req_cq, 8'h08);
    cpx_gnt = 1'b1;
    cyc();
    chk("t5_data_x", fp_cpx_data_ca, dat(2'b01, px));
    chk("t5_req_y", fp_cpx_req_cq, 8'h08);
    #2 arst_l = 1'b0;
    #1;
    chk("t5_rst_req", fp_cpx_req_cq, 8'h00);
    chk("t5_rst_req_pipe", req_pipe, 3'b000);
    chk("t5_rst_data", fp_cpx_data_ca, '0);
    chk("t5_rst_drop", drop_err, 1'b0);
    cpx_gnt = 1'b0;
    cyc();
    arst_l = 1'b1;
    chk("t5_rdy_after", pipe_rdy, 3'b111);
    set_pipe(0, 1'b1, 8'h10, 2'b11, pz);
    cyc();
    set_pipe(0, 1'b0, 8'h00, 2'b00, '0);
    chk("t5_no_bypass", fp_cpx_req_cq, 8'h00);
    cyc();
    chk("t5_req_new", fp_cpx_req_cq, 8'h10);
    chk("t5_req_pipe_new", req_pipe, 3'b001);
    cpx_gnt = 1'b1;
    cyc();
    chk("t5_data_new", fp_cpx_data_ca, dat(2'b11, pz));
    cyc();
    chk("t5_data_end", fp_cpx_data_ca, '0);
    chk("t5_y_lost", fp_cpx_req_cq, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fpu_out_arb.md
# fpu_out_arb

Parametrised FPU result output arbiter: the successor of the fixed three-pipe result-to-CPX output stage. It accepts results from NPIPE execution pipes through per-pipe FIFOs and selects one per cycle, fixed-priority or round-robin. It issues a one-hot core request to the CPX, holds the request until granted, and drives the registered CPX packet the cycle after the grant. It sits between the FPU pipe back-ends and the CPX request/data ports.

## Interface
Parameters:
- NPIPE, 3: number of result pipes; index 0 = div, 1 = mul, 2 = add in the default build
- NCORE, 8: CPX destinations; width of the one-hot core field
- PAY_W, 142: result payload bits per pipe (exc, cc, sign, exp, frac pre-packed)
- DEPTH, 2: entries per pipe FIFO; power of two, at least 2

Ports (clock and reset: one clock; reset is asynchronous and active-low):
- rclk  in  1  global clock
- arst_l  in  1  asynchronous reset, active low
- pipe_vld  in  NPIPE  result valid per pipe
- pipe_id  in  NPIPE*(NCORE+2)  per pipe: [NCORE+1:2] one-hot core, [1:0] thread
- pipe_pay  in  NPIPE*PAY_W  payload per pipe
- pipe_rdy  out  NPIPE  FIFO not full; push occurs on vld & rdy
- cpx_gnt  in  1  CPX accepts the current request this cycle
- fp_cpx_req_cq  out  NCORE  one-hot core request, registered
- req_pipe  out  NPIPE  one-hot source pipe of the current request
- fp_cpx_data_ca  out  PAY_W+3  {valid, thread[1:0], payload}, registered
- drop_err  out  1  sticky: an entry with an all-zero core field was discarded

## Operation
- Per-pipe FIFO: push on pipe_vld & pipe_rdy. pipe_rdy = ~full; it is combinational from occupancy, so a pop does not free space until the next cycle.
- Push with zero core field: the entry is not written, and drop_err sets and stays set until reset.
- Request stage, one entry: rq_vld, rq_core, rq_thread, rq_pay, rq_pipe.
- Load condition: the stage loads when ~rq_vld | cpx_gnt and at least one FIFO head is valid. The winner is popped in the same cycle.
- Arbitration: fixed priority, lowest pipe index first. Round-robin when built in (see Configuration).
- Outputs from the request stage: fp_cpx_req_cq = rq_vld ? rq_core : 0; req_pipe = rq_vld ? rq_pipe : 0.
- Grant without a request (cpx_gnt while ~rq_vld): ignored.
- Data register: on rq_vld & cpx_gnt it loads {1, rq_thread, rq_pay}; otherwise it loads all-zero. fp_cpx_data_ca is therefore a single-cycle pulse per grant.
- Back-to-back traffic: grant and load in the same cycle give one request per cycle with no bubble.

## Timing
- Reset values: fp_cpx_req_cq = 0, req_pipe = 0, fp_cpx_data_ca = 0, drop_err = 0, pipe_rdy = all ones, FIFOs empty, RR pointer = 0.
- Push-to-request: push at edge k; request visible after edge k+1 (1 cycle) when the stage is free.
- Grant-to-data: a grant in cycle n produces data in cycle n+1.
- Request held: fp_cpx_req_cq is held stable, with the same core, every cycle until granted.
- Full FIFO with pop and push offered in the same cycle: the push is refused because rdy=0; rdy rises the following cycle.
- Empty FIFO with push: the entry is arbitrated no earlier than the next cycle; there is no bypass.
- Reset mid-operation: FIFO contents, the request stage and the data register are lost; outputs return to reset values asynchronously.

## Configuration
- FPU_OUT_RR_EN defined:
  - Round-robin arbitration: search starts at the pointer.
  - On each load the pointer becomes (winner+1) mod NPIPE.
- FPU_OUT_RR_EN not defined: fixed priority with pipe 0 highest; no pointer flop is built.

## Structure
- Package fpu_out_pkg: ID field offsets (thread [1:0], core base 2), data-bus field offsets (valid at MSB, thread below it), and the default NPIPE/NCORE/PAY_W.
- Sub-module fpu_out_fifo: a parametrised DEPTH x (NCORE+2+PAY_W) FIFO with push, pop, head, empty and full; instantiated NPIPE times.
- The arbiter and request stage live in the top module.

## Test plan
- Single result: pipe 1 pushes id core=8'h04, thread=2, gnt held at 1 -> fp_cpx_req_cq=8'h04 the next cycle; fp_cpx_data_ca={1,2'b10,pay} one cycle later, then 0.
- Backpressure: gnt=0 for 5 cycles with DEPTH=2 and pipe 0 pushing every cycle -> req held for 5 cycles with the same core; pipe_rdy[0]=0 after 3 accepted pushes (one in stage, two in FIFO); no data pulse until the gnt cycle.
- Contention, fixed priority: all three pipes push together with gnt=1 -> grant order 0,0,… (pipe 0 continuously pushing starves pipes 1 and 2).
- Contention with FPU_OUT_RR_EN: all three pipes push continuously, gnt=1 -> req_pipe sequence 001,010,100,001.
- Zero core field: pipe 2 pushes core=0 -> no request; drop_err=1 and it stays 1.
- Async reset: arst_l low while req is pending -> req and data go to 0 at once; after release pipe_rdy is all ones and the first new push is serviced with 1-cycle latency.
